// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator datapath blocks.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic int nib_count(input int op_w);
    return op_w / NIB_W;
  endfunction

endpackage

// File: rtl/four_bit_unsigned_multiplier.sv
// Combinational 4x4 unsigned multiplier; the one datapath the sequencer time-shares.
module four_bit_unsigned_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/nibble_mul_sequencer.sv
// OP_W x OP_W unsigned multiplier built from one 4x4 multiplier, one nibble pair per cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// out_valid is held with product stable until that edge, in_ready is high only in IDLE.
module nibble_mul_sequencer
  import calc_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] product,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int N  = nib_count(OP_W);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * OP_W;

  state_t          state;
  logic [OP_W-1:0] a_r;
  logic [OP_W-1:0] b_r;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   i;
  logic [CW-1:0]   j;

  logic [OP_W-1:0] a_sh;
  logic [OP_W-1:0] b_sh;
  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [7:0]      pp;
  logic [PW-1:0]   pp_ext;
  logic [PW-1:0]   acc_next;
  logic            last_i;
  logic            last_j;

  // Nibble selection by shifting the operand down so the low nibble is the one in use.
  assign a_sh  = a_r >> (NIB_W * int'(i));
  assign b_sh  = b_r >> (NIB_W * int'(j));
  assign a_nib = a_sh[NIB_W-1:0];
  assign b_nib = b_sh[NIB_W-1:0];

  four_bit_unsigned_multiplier u_mul (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  assign pp_ext   = PW'(pp);
  assign acc_next = acc + (pp_ext << (NIB_W * (int'(i) + int'(j))));
  assign last_i   = (i == CW'(N - 1));
  assign last_j   = (j == CW'(N - 1));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          if (last_i) begin
            i <= '0;
            if (last_j) begin
              product   <= acc_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_mul_sequencer.sv
// Directed bench for nibble_mul_sequencer at OP_W=8: vector table plus multi-cycle corner cases.
module tb_nibble_mul_sequencer;

  localparam int OP_W = 8;
  localparam int PW   = 2 * OP_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OP_W-1:0] a_in = '0;
  logic [OP_W-1:0] b_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] product;
  logic          busy;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [PW-1:0]   exp;
  } vec_t;

  vec_t vecs[9];

  nibble_mul_sequencer #(.OP_W(OP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // driver: one accept edge, then wait for out_valid; lat counts edges including the accept edge
  task automatic run_op(input logic [OP_W-1:0] av, input logic [OP_W-1:0] bv,
                        output logic [PW-1:0] prod, output int lat);
    a_in = av;
    b_in = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    prod = product;
  endtask

  initial begin
    logic [PW-1:0] prod;
    int lat;
    int cyc;
    int acc1;
    int acc2;
    int got;
    bit stable_ir;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h12, 8'h34, 16'h03A8};
    vecs[2] = '{8'hA5, 8'h5A, 16'h3A02};
    vecs[3] = '{8'h00, 8'hAB, 16'h0000};
    vecs[4] = '{8'h01, 8'hC7, 16'h00C7};
    vecs[5] = '{8'h0F, 8'h10, 16'h00F0};
    vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[7] = '{8'hF0, 8'h0F, 16'h0E10};
    vecs[8] = '{8'h10, 8'h10, 16'h0100};

    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // vector table
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(vecs[k].exp);
      run_op(vecs[k].a, vecs[k].b, prod, lat);
      chk($sformatf("vec%0d_latency", k), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'd1);
      chk($sformatf("vec%0d_product", k), 32'(prod), 32'(exp_q.pop_front()));
      step();
      chk($sformatf("vec%0d_handoff_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_handoff_ready", k), 32'(in_ready), 32'd1);
    end

    // back-to-back issue with in_valid held high
    exp_q.push_back(16'h03A8);
    exp_q.push_back(16'h3A02);
    a_in = 8'h12;
    b_in = 8'h34;
    in_valid = 1'b1;
    cyc = 0;
    acc1 = -1;
    acc2 = -1;
    got = 0;
    while (got < 2 && cyc < 40) begin
      if (in_ready && in_valid) begin
        if (acc1 < 0) acc1 = cyc;
        else acc2 = cyc;
      end
      step();
      cyc++;
      if (acc1 >= 0 && acc2 < 0) begin
        a_in = 8'hA5;
        b_in = 8'h5A;
      end
      if (acc2 >= 0) in_valid = 1'b0;
      if (out_valid) begin
        got++;
        chk($sformatf("b2b_product%0d", got), 32'(product), 32'(exp_q.pop_front()));
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(got), 32'd2);
    chk("b2b_interval", 32'(acc2 - acc1), 32'd6);
    step();

    // backpressure
    out_ready = 1'b0;
    run_op(8'h0F, 8'h10, prod, lat);
    chk("bp_latency", 32'(lat), 32'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_product%0d", k), 32'(product), 32'h00F0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_product_kept", 32'(product), 32'h00F0);

    // in_valid with new operands during MUL is ignored
    a_in = 8'h02;
    b_in = 8'h03;
    in_valid = 1'b1;
    step();
    a_in = 8'h33;
    b_in = 8'h33;
    stable_ir = 1'b1;
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (in_ready) stable_ir = 1'b0;
      step();
      lat++;
    end
    if (in_ready) stable_ir = 1'b0;
    in_valid = 1'b0;
    chk("ign_latency", 32'(lat), 32'd5);
    chk("ign_in_ready_low", 32'(stable_ir), 32'd1);
    chk("ign_product", 32'(product), 32'h0006);
    step();
    chk("ign_back_idle", 32'(dbg_state), 32'd0);
    step();
    chk("ign_no_reaccept", 32'(in_ready), 32'd1);

    // reset during MUL
    a_in = 8'hFF;
    b_in = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_state", 32'(dbg_state), 32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_product", 32'(product), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    got = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) got++;
    end
    chk("mrst_no_leak", 32'(got), 32'd0);
    run_op(8'h10, 8'h10, prod, lat);
    chk("mrst_after_latency", 32'(lat), 32'd5);
    chk("mrst_after_product", 32'(prod), 32'h0100);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_mul_sequencer.md
Name: nibble_mul_sequencer

Overview:
- Sequential unsigned multiplier controller. Computes an OP_W x OP_W product by time-sharing one combinational 4x4 unsigned multiplier, one nibble pair per cycle, with shift-accumulate.
- Sits between the calculator operand registers and the result mux. Uses valid/ready handshakes on both sides.

Parameters:
OP_W, 8, operand width in bits. Legal values are 4, 8, 12 or 16 (a multiple of 4). The number of nibbles is N = OP_W/4.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  OP_W  multiplicand, unsigned
b  input  OP_W  multiplier, unsigned
out_valid  output  1  product valid; held until accepted
out_ready  input  1  consumer accepts product
product  output  2*OP_W  unsigned product, registered
busy  output  1  high in MUL and DONE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, step counters=0. Operand registers are don't-care.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: register a and b, clear the accumulator, set i=0 and j=0, go to MUL.
  - in_valid=0: stay in IDLE.
- MUL (one cycle per nibble pair, N*N cycles total):
  - Multiplier inputs: A nibble a_r[4i+3:4i] and B nibble b_r[4j+3:4j].
  - Each cycle: acc <= acc + (pp8 zero-extended to 2*OP_W) << 4*(i+j).
  - Step order: i increments fastest; when i=N-1, i wraps to 0 and j increments.
  - After the step with i=N-1 and j=N-1: product <= final acc, out_valid <= 1, go to DONE.
- Latency: out_valid rises exactly N*N+1 clock edges after the accepting edge. This is 5 edges for OP_W=8 and 2 edges for OP_W=4.
- DONE:
  - out_valid=1 and product stable.
  - Edge with out_ready=1: out_valid <= 0, go to IDLE.
  - out_ready=0: hold indefinitely with product unchanged.
- Back-to-back requests: in_ready is low in DONE, so there is no accept in the same cycle as the handoff. The minimum issue interval is N*N+2 cycles.
- in_valid while in MUL or DONE: ignored; operands are not sampled and the in-flight computation is not disturbed.
- Arithmetic:
  - Accumulator is 2*OP_W bits and never overflows, because the max sum is (2^OP_W-1)^2.
  - Partial product is 8 bits; no sign handling.
- product holds its last value after the handoff until the next DONE. It is 0 after reset.
- Reset mid-MUL or mid-DONE: everything returns to reset values on that edge, and the partial result is discarded. No out_valid pulse may leak after reset.
- out_ready is ignored outside DONE.

Decomposition:
- calc_pkg holds:
  - the state enum (IDLE, MUL, DONE);
  - constant NIB_W=4;
  - function nib_count(OP_W) returning OP_W/4.
- Sub-module: one instance of four_bit_unsigned_multiplier (4-bit A/B, 8-bit product) as the shared datapath.
- Nibble muxes, counters, accumulator and FSM are local to nibble_mul_sequencer.

Test Plan:
- OP_W=8, a=0xFF, b=0xFF, out_ready=1 -> out_valid rises 5 edges after accept, product=0xFE01, then in_ready=1 the next cycle.
- OP_W=8, a=0x12 then 0xA5, b=0x34 then 0x5A, issued back-to-back -> products 0x03A8 and 0x3A02 in order. The second accept occurs no earlier than 6 cycles after the first.
- OP_W=8, a=0x00, b=0xAB -> product=0x0000. a=0x01, b=0xC7 -> product=0x00C7.
- Backpressure: a=0x0F, b=0x10, out_ready held low for 3 cycles after out_valid -> out_valid and product=0x00F0 stay stable; transfer completes on the first out_ready=1 edge.
- in_valid asserted with new operands (0x33,0x33) during MUL of (0x02,0x03) -> result 0x0006, new operands not captured, in_ready=0 throughout.
- rst pulsed during MUL step 2 -> next edge state=IDLE, out_valid=0, product=0, in_ready=1. A following a=0x10, b=0x10 yields 0x0100.
